exc_sequencer: RTL and testbench

Multicycle exception sequencer for the CPU datapath. It detects the three exception causes: invalid opcode, arithmetic overflow and divide-by-zero. On a detected exception it takes ownership of the memory-address selector, saves EPC, and reads the handler byte from vector address 253, 254 or 255. It then loads PC with that byte zero-extended. Outside an exception it passes the main control unit's address selection through unchanged, so it sits between the main FSM and the address mux.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/exc_sequencer_if.sv | 42 ++++
 rtl/exc_sequencer.sv | 99 +++++++++
 tb/tb_exc_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: memory-address selector codes, exception
// cause codes and the exception sequencer state type.
package cpu_pkg;

    localparam logic [2:0] IORD_ALU    = 3'b000;
    localparam logic [2:0] IORD_ALUOUT = 3'b001;
    localparam logic [2:0] IORD_V253   = 3'b010;
    localparam logic [2:0] IORD_V254   = 3'b011;
    localparam logic [2:0] IORD_V255   = 3'b100;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_OPCODE   = 2'd1;
    localparam logic [1:0] CAUSE_OVERFLOW = 2'd2;
    localparam logic [1:0] CAUSE_DIV0     = 2'd3;

    typedef enum logic [2:0] {
        EXC_IDLE  = 3'd0,
        EXC_SAVE  = 3'd1,
        EXC_READ  = 3'd2,
        EXC_LATCH = 3'd3,
        EXC_JUMP  = 3'd4
    } exc_state_t;

    // Wait-counter preload for a given memory latency; latency clamped to 1..7.
    function automatic logic [2:0] wait_load(input int lat);
        if (lat <= 1) return 3'd0;
        if (lat >= 7) return 3'd6;
        return 3'(lat - 1);
    endfunction

endpackage

// File: rtl/exc_sequencer_if.sv
// Control-side bundle of the exception sequencer. master = main control unit
// side, slave = sequencer. exc_cause exists only when EXC_CAUSE_EN is defined.
interface exc_sequencer_if;
    import cpu_pkg::*;

    // Level signals, no handshake: flags are sampled by the sequencer on every
    // rising edge while IDLE; busy tells the main FSM to stall.
    logic [2:0] ctrl_iord_sel;
    logic       exc_opcode;
    logic       exc_overflow;
    logic       exc_div0;
    logic [2:0] iord_sel;
    logic       epc_write;
    logic       mdr_write;
    logic       pc_write;
    logic       pc_src_exc;
    logic       busy;
    logic       exc_done;
    exc_state_t state;
`ifdef EXC_CAUSE_EN
    logic [1:0] exc_cause;
`endif

    modport master (
        output ctrl_iord_sel, exc_opcode, exc_overflow, exc_div0,
        input  iord_sel, epc_write, mdr_write, pc_write, pc_src_exc,
        input  busy, exc_done, state
`ifdef EXC_CAUSE_EN
        , input exc_cause
`endif
    );

    modport slave (
        input  ctrl_iord_sel, exc_opcode, exc_overflow, exc_div0,
        output iord_sel, epc_write, mdr_write, pc_write, pc_src_exc,
        output busy, exc_done, state
`ifdef EXC_CAUSE_EN
        , output exc_cause
`endif
    );

endinterface

// File: rtl/exc_sequencer.sv
// Multicycle exception sequencer: saves EPC, reads the handler byte from vector
// 253/254/255 and loads PC. Define EXC_CAUSE_EN to add the latched exc_cause.
module exc_sequencer #(
    parameter int MEM_LAT = 1
) (
    input logic            clk,
    input logic            reset,
    exc_sequencer_if.slave bus
);
    import cpu_pkg::*;

    localparam logic [2:0] WAIT_LOAD = wait_load(MEM_LAT);

    exc_state_t state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic [2:0] vec, vec_nxt;
    logic       exc_any;

    assign exc_any   = bus.exc_opcode | bus.exc_overflow | bus.exc_div0;
    assign bus.state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EXC_IDLE;
            cnt   <= 3'd0;
            vec   <= IORD_ALU;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            vec   <= vec_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        vec_nxt   = vec;
        case (state)
            EXC_IDLE: begin
                if (exc_any) begin
                    state_nxt = EXC_SAVE;
                    if (bus.exc_opcode)        vec_nxt = IORD_V253;
                    else if (bus.exc_overflow) vec_nxt = IORD_V254;
                    else                       vec_nxt = IORD_V255;
                end
            end
            EXC_SAVE: begin
                state_nxt = EXC_READ;
                cnt_nxt   = WAIT_LOAD;
            end
            // READ lasts WAIT_LOAD+1 cycles, i.e. the memory latency.
            EXC_READ: begin
                if (cnt != 3'd0) cnt_nxt = cnt - 3'd1;
                else             state_nxt = EXC_LATCH;
            end
            EXC_LATCH: state_nxt = EXC_JUMP;
            EXC_JUMP:  state_nxt = EXC_IDLE;
            default:   state_nxt = EXC_IDLE;
        endcase
    end

    always_comb begin
        bus.iord_sel   = vec;
        bus.epc_write  = 1'b0;
        bus.mdr_write  = 1'b0;
        bus.pc_write   = 1'b0;
        bus.pc_src_exc = 1'b0;
        bus.exc_done   = 1'b0;
        bus.busy       = (state != EXC_IDLE);
        case (state)
            EXC_IDLE:  bus.iord_sel = bus.ctrl_iord_sel;
            EXC_SAVE:  bus.epc_write = 1'b1;
            EXC_LATCH: bus.mdr_write = 1'b1;
            EXC_JUMP: begin
                bus.pc_write   = 1'b1;
                bus.pc_src_exc = 1'b1;
                bus.exc_done   = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef EXC_CAUSE_EN
    logic [1:0] cause;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cause <= CAUSE_NONE;
        end else if (state == EXC_IDLE && exc_any) begin
            if (bus.exc_opcode)        cause <= CAUSE_OPCODE;
            else if (bus.exc_overflow) cause <= CAUSE_OVERFLOW;
            else                       cause <= CAUSE_DIV0;
        end
    end

    assign bus.exc_cause = cause;
`endif

endmodule

// File: tb/tb_exc_sequencer.sv
// Bench for exc_sequencer: two instances (MEM_LAT=1 and MEM_LAT=3) share one
// stimulus stream and are compared every cycle against a sequence-position model.
module tb_exc_sequencer;
    import cpu_pkg::*;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic       clk;
    logic       reset;
    logic [2:0] ctrl_iord_sel;
    logic       exc_opcode;
    logic       exc_overflow;
    logic       exc_div0;
    logic       check_en;

    int n_checks = 0;
    int n_errors = 0;

    exc_sequencer_if bus_a ();
    exc_sequencer_if bus_b ();

    assign bus_a.ctrl_iord_sel = ctrl_iord_sel;
    assign bus_a.exc_opcode    = exc_opcode;
    assign bus_a.exc_overflow  = exc_overflow;
    assign bus_a.exc_div0      = exc_div0;
    assign bus_b.ctrl_iord_sel = ctrl_iord_sel;
    assign bus_b.exc_opcode    = exc_opcode;
    assign bus_b.exc_overflow  = exc_overflow;
    assign bus_b.exc_div0      = exc_div0;

    exc_sequencer #(.MEM_LAT(LAT_A)) u_lat1 (.clk(clk), .reset(reset), .bus(bus_a));
    exc_sequencer #(.MEM_LAT(LAT_B)) u_lat3 (.clk(clk), .reset(reset), .bus(bus_b));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // packed outputs: {iord_sel, epc, mdr, pc, pc_src, busy, done}
    logic [8:0] act_v [2];
    assign act_v[0] = {bus_a.iord_sel, bus_a.epc_write, bus_a.mdr_write, bus_a.pc_write,
                       bus_a.pc_src_exc, bus_a.busy, bus_a.exc_done};
    assign act_v[1] = {bus_b.iord_sel, bus_b.epc_write, bus_b.mdr_write, bus_b.pc_write,
                       bus_b.pc_src_exc, bus_b.busy, bus_b.exc_done};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: position within the exception sequence (0 = idle, 1..len)
    int         pos   [2];
    logic [2:0] mvec  [2];
    logic [1:0] mcause[2];

    function automatic int eff_lat(input int lat);
        if (lat < 1) return 1;
        if (lat > 7) return 7;
        return lat;
    endfunction

    function automatic int seq_len(input int k);
        return 3 + eff_lat((k == 0) ? LAT_A : LAT_B);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                pos[k]    <= 0;
                mvec[k]   <= 3'b000;
                mcause[k] <= 2'd0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (pos[k] == 0) begin
                    if (exc_opcode || exc_overflow || exc_div0) begin
                        pos[k]    <= 1;
                        mvec[k]   <= exc_opcode ? 3'b010 : (exc_overflow ? 3'b011 : 3'b100);
                        mcause[k] <= exc_opcode ? 2'd1 : (exc_overflow ? 2'd2 : 2'd3);
                    end
                end else if (pos[k] == seq_len(k)) begin
                    pos[k] <= 0;
                end else begin
                    pos[k] <= pos[k] + 1;
                end
            end
        end
    end

    function automatic logic [8:0] exp_out(input int k);
        int         p;
        int         len;
        logic [2:0] iord;
        logic       busy_e, epc_e, mdr_e, last_e;
        p      = pos[k];
        len    = seq_len(k);
        busy_e = (p != 0);
        iord   = busy_e ? mvec[k] : ctrl_iord_sel;
        epc_e  = (p == 1);
        mdr_e  = (p == len - 1);
        last_e = (p == len);
        return {iord, epc_e, mdr_e, last_e, last_e, busy_e, last_e};
    endfunction

    // scoreboard compare, every cycle away from the active edge
    always @(negedge clk) begin
        if (check_en) begin
            chk("model_lat1", {23'd0, act_v[0]}, {23'd0, exp_out(0)});
            chk("model_lat3", {23'd0, act_v[1]}, {23'd0, exp_out(1)});
`ifdef EXC_CAUSE_EN
            chk("model_cause_lat1", {30'd0, bus_a.exc_cause}, {30'd0, mcause[0]});
            chk("model_cause_lat3", {30'd0, bus_b.exc_cause}, {30'd0, mcause[1]});
`endif
        end
    end

    // driver tasks
    task automatic pulse(input logic [2:0] which);
        @(posedge clk);
        #1;
        {exc_opcode, exc_overflow, exc_div0} = which;
        @(posedge clk);
        #1;
        {exc_opcode, exc_overflow, exc_div0} = 3'b000;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bus_a.busy || bus_b.busy) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", {31'd0, bus_a.busy | bus_b.busy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [2:0] pt_tab [4];
    logic [2:0] ov_iord[5];
    logic [4:0] ov_epc, ov_mdr, ov_pc, ov_busy;
    int         busy_cnt, done_at, pc_seen;

    initial begin
        pt_tab  = '{3'b000, 3'b001, 3'b011, 3'b100};
        ov_iord = '{3'b011, 3'b011, 3'b011, 3'b011, 3'b001};
        ov_epc  = 5'b10000;
        ov_mdr  = 5'b00100;
        ov_pc   = 5'b00010;
        ov_busy = 5'b11110;

        reset = 1'b1;
        check_en = 1'b0;
        ctrl_iord_sel = 3'b001;
        {exc_opcode, exc_overflow, exc_div0} = 3'b000;

        // reset state
        #3;
        chk("reset_busy", {31'd0, bus_a.busy | bus_b.busy}, 32'd0);
        chk("reset_iord", {29'd0, bus_a.iord_sel}, 32'h1);
        chk("reset_enables", {28'd0, bus_b.epc_write, bus_b.mdr_write, bus_b.pc_write,
                              bus_b.exc_done}, 32'd0);
`ifdef EXC_CAUSE_EN
        chk("reset_cause", {30'd0, bus_a.exc_cause}, 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_en = 1'b1;

        // pass-through
        for (int i = 0; i < 4; i++) begin
            ctrl_iord_sel = pt_tab[i];
            @(negedge clk);
            chk("pass_iord", {29'd0, bus_a.iord_sel}, {29'd0, pt_tab[i]});
            chk("pass_busy", {31'd0, bus_a.busy | bus_b.busy}, 32'd0);
            @(posedge clk);
            #1;
        end
        ctrl_iord_sel = 3'b001;

        // overflow at MEM_LAT=1
        pulse(3'b010);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("ovf_iord", {29'd0, bus_a.iord_sel}, {29'd0, ov_iord[i]});
            chk("ovf_epc",  {31'd0, bus_a.epc_write}, {31'd0, ov_epc[4-i]});
            chk("ovf_mdr",  {31'd0, bus_a.mdr_write}, {31'd0, ov_mdr[4-i]});
            chk("ovf_pc",   {29'd0, bus_a.pc_write, bus_a.pc_src_exc, bus_a.exc_done},
                {29'd0, {3{ov_pc[4-i]}}});
            chk("ovf_busy", {31'd0, bus_a.busy}, {31'd0, ov_busy[4-i]});
        end
        wait_idle();

        // priority: all three flags together
        pulse(3'b111);
        @(negedge clk);
        chk("prio_iord_lat1", {29'd0, bus_a.iord_sel}, 32'h2);
        chk("prio_iord_lat3", {29'd0, bus_b.iord_sel}, 32'h2);
`ifdef EXC_CAUSE_EN
        chk("prio_cause", {30'd0, bus_a.exc_cause}, 32'd1);
`endif
        wait_idle();

        // latency: div0 at MEM_LAT=3
        busy_cnt = 0;
        done_at  = 0;
        pulse(3'b001);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus_b.busy) busy_cnt++;
            if (bus_b.exc_done) done_at = i + 1;
            if (i < 4) chk("lat3_iord", {29'd0, bus_b.iord_sel}, 32'h4);
        end
        chk("lat3_busy_cycles", busy_cnt, 32'd6);
        chk("lat3_done_cycle", done_at, 32'd6);
        wait_idle();

        // flags ignored while sequencing
        pulse(3'b010);
        @(posedge clk);
        #1;
        exc_opcode = 1'b1;
        @(posedge clk);
        #1;
        exc_opcode = 1'b0;
        @(negedge clk);
        chk("ign_iord_latch", {29'd0, bus_a.iord_sel}, 32'h3);
        chk("ign_mdr", {31'd0, bus_a.mdr_write}, 32'd1);
        @(negedge clk);
        chk("ign_iord_jump", {29'd0, bus_a.iord_sel}, 32'h3);
        chk("ign_pc", {31'd0, bus_a.pc_write}, 32'd1);
        @(negedge clk);
        chk("ign_idle", {31'd0, bus_a.busy}, 32'd0);
`ifdef EXC_CAUSE_EN
        chk("ign_cause", {30'd0, bus_b.exc_cause}, 32'd2);
`endif
        wait_idle();

        // asynchronous reset during LATCH
        pulse(3'b010);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("rst_pre_latch", {31'd0, bus_a.mdr_write}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_enables", {27'd0, bus_a.epc_write, bus_a.mdr_write, bus_a.pc_write,
                            bus_a.busy, bus_a.exc_done}, 32'd0);
        chk("rst_iord", {29'd0, bus_a.iord_sel}, 32'h1);
        chk("rst_busy_lat3", {31'd0, bus_b.busy}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        pc_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus_a.pc_write || bus_b.pc_write) pc_seen++;
        end
        chk("rst_no_pc_write", pc_seen, 32'd0);
`ifdef EXC_CAUSE_EN
        chk("rst_cause", {30'd0, bus_a.exc_cause}, 32'd0);
`endif

        @(posedge clk);
        #1;
        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
